// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//   Single-transfer APB requester. A one-cycle start command (address, write
//   data, direction) is turned into one SETUP/ACCESS transfer on the APB bus.
//   PREADY wait states are honoured without limit. Completion is reported with
//   a one-cycle done pulse, the read data and the completer error status.
//
// Ports
//   i_clk, i_reset_n   clock (rising edge), synchronous active-low reset
//   PADDR/PWRITE/PWDATA/PSELx/PENABLE   APB request outputs (registered)
//   PRDATA/PREADY/PSLVERR               APB completer responses
//   i_start/i_addr/i_wdata/i_write      command, sampled only while idle
//   o_done     one-cycle pulse in the cycle after the transfer completes
//   o_rdata    read data of the last completed read
//   o_slverr   error flag of the last completed transfer
// -----------------------------------------------------------------------------
module apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PSELx,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_write,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_slverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
  logic                    pwrite_q,  pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,  pwdata_d;
  logic                    psel_q,    psel_d;
  logic                    penable_q, penable_d;
  logic                    done_q,    done_d;
  logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
  logic                    slverr_q,  slverr_d;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = SETUP;
          paddr_d  = i_addr;
          pwdata_d = i_wdata;
          pwrite_d = i_write;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // PRDATA/PSLVERR are only meaningful in the ready ACCESS cycle.
        if (PREADY) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          slverr_d = PSLVERR;
          if (!pwrite_q) begin
            rdata_d = PRDATA;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus strobes are registered from the next state so they line up with
    // the phase the FSM is entering.
    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
    end
  end

  assign PADDR    = paddr_q;
  assign PWRITE   = pwrite_q;
  assign PWDATA   = pwdata_q;
  assign PSELx    = psel_q;
  assign PENABLE  = penable_q;
  assign o_done   = done_q;
  assign o_rdata  = rdata_q;
  assign o_slverr = slverr_q;

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
//   Self-checking bench for apb_master. Drives commands and a behavioural APB
//   completer, and compares the bus timeline, latency, done pulse, read data
//   and error flag against expectations derived from the transfer rules.
// -----------------------------------------------------------------------------
module tb_apb_master;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PSELx;
  logic        PENABLE;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        i_write = 1'b0;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_slverr;

  always #5 clk = ~clk;

  apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSELx(PSELx), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .i_start(i_start), .i_addr(i_addr), .i_wdata(i_wdata), .i_write(i_write),
    .o_done(o_done), .o_rdata(o_rdata), .o_slverr(o_slverr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what the host-visible status should be after the
  // sequence of completed transfers so far.
  logic [31:0] exp_rdata  = '0;
  logic        exp_slverr = 1'b0;

  // Observations recorded by run_xfer.
  int lat, n_setup, n_access;
  bit bad_stable, bad_pen, got_done;

  // Issue one command at the current negedge and act as the completer.
  // Returns at the negedge where o_done is seen (or when the budget expires).
  task automatic run_xfer(input logic [31:0] a, input logic [31:0] wd, input logic w,
                          input int waits, input logic [31:0] rd, input logic err,
                          input bit poke_start);
    bit first;
    i_start = 1'b1; i_addr = a; i_wdata = wd; i_write = w;
    lat = 0; n_setup = 0; n_access = 0;
    bad_stable = 0; bad_pen = 0; got_done = 0; first = 1;
    for (int c = 0; c < waits + 20; c++) begin
      @(negedge clk);
      lat++;
      i_start = 1'b0;
      i_addr  = $urandom; i_wdata = $urandom; i_write = 1'($urandom);
      PREADY  = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
      if (o_done) begin
        got_done = 1;
        if (PSELx || PENABLE) bad_pen = 1;
        break;
      end
      if (PSELx) begin
        if (PADDR !== a || PWDATA !== wd || PWRITE !== w) bad_stable = 1;
        if (first && PENABLE) bad_pen = 1;
        first = 0;
        if (PENABLE) begin
          n_access++;
          if (n_access == waits + 1) begin
            PREADY = 1'b1; PSLVERR = err; PRDATA = rd;
          end else if (poke_start) begin
            i_start = 1'b1;
          end
        end else begin
          n_setup++;
        end
      end else if (PENABLE) begin
        bad_pen = 1;
      end
    end
    PREADY = 1'b0;
    i_start = 1'b0;
    if (got_done) begin
      if (!w) exp_rdata = rd;
      exp_slverr = err;
    end
  endtask

  task automatic test_reset();
    int busy;
    i_reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({PSELx, PENABLE, PWRITE} !== 3'b000) $display("FAIL rst_strobes got %b want 000", {PSELx, PENABLE, PWRITE}); else n_pass++;
    n_checks++; if ({PADDR, PWDATA} !== 64'd0) $display("FAIL rst_bus got %h/%h want 0/0", PADDR, PWDATA); else n_pass++;
    n_checks++; if ({o_done, o_slverr, o_rdata} !== 34'd0) $display("FAIL rst_status got %b %b %h want 0 0 0", o_done, o_slverr, o_rdata); else n_pass++;
    i_reset_n = 1'b1;
    busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (PSELx !== 1'b0 || o_done !== 1'b0) busy++;
    end
    n_checks++; if (busy !== 0) $display("FAIL rst_idle got %0d busy cycles want 0", busy); else n_pass++;
  endtask

  task automatic test_write_waits();
    run_xfer(32'h1000, 32'hDEADBEEF, 1'b1, 2, 32'h0, 1'b0, 0);
    n_checks++; if (got_done !== 1'b1) $display("FAIL wr_done got %0d want 1", got_done); else n_pass++;
    n_checks++; if (lat !== 5) $display("FAIL wr_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (n_setup !== 1 || n_access !== 3) $display("FAIL wr_phases got %0d/%0d want 1/3", n_setup, n_access); else n_pass++;
    n_checks++; if (bad_stable || bad_pen) $display("FAIL wr_bus got stable_err=%0d pen_err=%0d want 0/0", bad_stable, bad_pen); else n_pass++;
    n_checks++; if (o_slverr !== 1'b0 || o_rdata !== 32'h0) $display("FAIL wr_status got %b %h want 0 00000000", o_slverr, o_rdata); else n_pass++;
    @(negedge clk);
    n_checks++; if (o_done !== 1'b0) $display("FAIL wr_done_len got %b want 0", o_done); else n_pass++;
  endtask

  task automatic test_read();
    run_xfer(32'h1000, 32'h12345678, 1'b0, 1, 32'hDEADBEEF, 1'b0, 0);
    n_checks++; if (got_done !== 1'b1 || lat !== 4) $display("FAIL rd_latency got done=%0d lat=%0d want 1/4", got_done, lat); else n_pass++;
    n_checks++; if (bad_stable || bad_pen) $display("FAIL rd_bus got stable_err=%0d pen_err=%0d want 0/0", bad_stable, bad_pen); else n_pass++;
    n_checks++; if (o_rdata !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", o_rdata); else n_pass++;
    @(negedge clk);
    n_checks++; if (o_done !== 1'b0) $display("FAIL rd_done_len got %b want 0", o_done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_xfer(32'h2000, 32'hCAFEBABE, 1'b1, 0, 32'h55AA55AA, 1'b0, 0);
    n_checks++; if (got_done !== 1'b1 || lat !== 3) $display("FAIL b2b_wr got done=%0d lat=%0d want 1/3", got_done, lat); else n_pass++;
    n_checks++; if (o_rdata !== 32'hDEADBEEF) $display("FAIL b2b_wr_keeps_rdata got %h want deadbeef", o_rdata); else n_pass++;
    run_xfer(32'h2000, 32'h0, 1'b0, 0, 32'hCAFEBABE, 1'b0, 0);
    n_checks++; if (got_done !== 1'b1 || lat !== 3 || n_setup !== 1) $display("FAIL b2b_rd got done=%0d lat=%0d setup=%0d want 1/3/1", got_done, lat, n_setup); else n_pass++;
    n_checks++; if (bad_stable || bad_pen) $display("FAIL b2b_bus got stable_err=%0d pen_err=%0d want 0/0", bad_stable, bad_pen); else n_pass++;
    n_checks++; if (o_rdata !== 32'hCAFEBABE) $display("FAIL b2b_rdata got %h want cafebabe", o_rdata); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_error();
    run_xfer(32'h3000, 32'h0BADF00D, 1'b1, 1, 32'h0, 1'b1, 0);
    n_checks++; if (got_done !== 1'b1 || o_slverr !== 1'b1) $display("FAIL err_set got done=%0d slverr=%b want 1/1", got_done, o_slverr); else n_pass++;
    n_checks++; if (o_rdata !== 32'hCAFEBABE) $display("FAIL err_rdata got %h want cafebabe", o_rdata); else n_pass++;
    @(negedge clk);
    n_checks++; if (o_slverr !== 1'b1) $display("FAIL err_hold got %b want 1", o_slverr); else n_pass++;
    run_xfer(32'h3004, 32'h0, 1'b0, 2, 32'h00C0FFEE, 1'b0, 0);
    n_checks++; if (got_done !== 1'b1 || o_slverr !== 1'b0) $display("FAIL err_clear got done=%0d slverr=%b want 1/0", got_done, o_slverr); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_robust();
    int busy;
    run_xfer(32'h4000, 32'h11112222, 1'b1, 3, 32'h0, 1'b0, 1);
    n_checks++; if (got_done !== 1'b1 || lat !== 6 || bad_stable) $display("FAIL poke_xfer got done=%0d lat=%0d stable_err=%0d want 1/6/0", got_done, lat, bad_stable); else n_pass++;
    busy = 0;
    repeat (4) begin
      @(negedge clk);
      if (PSELx !== 1'b0 || o_done !== 1'b0) busy++;
    end
    n_checks++; if (busy !== 0) $display("FAIL poke_no_extra got %0d busy cycles want 0", busy); else n_pass++;

    // Abort in ACCESS with PREADY high: reset must win, no completion.
    i_start = 1'b1; i_addr = 32'h5000; i_wdata = 32'h77; i_write = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 10 && !(PSELx && PENABLE); c++) @(negedge clk);
    n_checks++; if (PENABLE !== 1'b1) $display("FAIL abort_reach_access got %b want 1", PENABLE); else n_pass++;
    i_reset_n = 1'b0; PREADY = 1'b1; PRDATA = 32'h99999999; PSLVERR = 1'b1;
    @(negedge clk);
    n_checks++; if ({PSELx, PENABLE, o_done} !== 3'b000) $display("FAIL abort_drop got %b want 000", {PSELx, PENABLE, o_done}); else n_pass++;
    i_reset_n = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0;
    @(negedge clk);
    n_checks++; if ({o_done, o_slverr, o_rdata, PADDR} !== 66'd0) $display("FAIL abort_status got %b %b %h %h want all 0", o_done, o_slverr, o_rdata, PADDR); else n_pass++;
    exp_rdata = '0; exp_slverr = 1'b0;
  endtask

  task automatic test_random();
    int errs;
    logic [31:0] a, wd, rd;
    logic w, e;
    int waits;
    bit b2b;
    errs = 0;
    for (int i = 0; i < 25; i++) begin
      a = $urandom; wd = $urandom; rd = $urandom;
      w = 1'($urandom); e = 1'($urandom); waits = $urandom_range(0, 4);
      b2b = 1'($urandom);
      run_xfer(a, wd, w, waits, rd, e, 1'($urandom));
      if (got_done !== 1'b1 || lat !== 3 + waits || n_setup !== 1 || n_access !== waits + 1 ||
          bad_stable || bad_pen || o_rdata !== exp_rdata || o_slverr !== exp_slverr) begin
        errs++;
        $display("FAIL rand_xfer%0d got done=%0d lat=%0d rdata=%h slverr=%b want 1/%0d/%h/%b", i,
                 got_done, lat, o_rdata, o_slverr, 3 + waits, exp_rdata, exp_slverr);
      end
      if (!b2b) begin
        @(negedge clk);
        if (o_done !== 1'b0 || PSELx !== 1'b0) begin
          errs++;
          $display("FAIL rand_idle%0d got done=%b psel=%b want 0/0", i, o_done, PSELx);
        end
      end
    end
    n_checks++; if (errs !== 0) $display("FAIL rand_summary got %0d errors want 0", errs); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_write_waits();
    test_read();
    test_back_to_back();
    test_error();
    test_robust();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
